// File: rtl/pea_ctrl_gen2.sv
// PE-array controller: runs a flush/compute pass for every input channel,
// output channel and output tile. Supports stride, 1x1/3x3 kernels, stalls and abort.
module pea_ctrl_gen2 #(
    parameter int TILE_COLS    = 16,
    parameter int TILE_ROWS    = 8,
    parameter int CH_CNT_WIDTH = 10,
    parameter int FMS_WIDTH    = 8,
    parameter int FLUSH_DEPTH  = 5,
    parameter int PVALID_LAT   = 3
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [CH_CNT_WIDTH-1:0] cfg_chi,
    input  logic [CH_CNT_WIDTH-1:0] cfg_cho,
    input  logic [1:0]              cfg_stride,
    input  logic                    cfg_k3,
    input  logic [FMS_WIDTH-1:0]    ifm_size,
    input  logic                    start_conv,
    input  logic                    abort,
    input  logic                    data_ready,
    output logic                    ifm_read,
    output logic                    wgt_read,
    output logic                    pvalid,
    output logic [TILE_ROWS-1:0]    row_mask,
    output logic                    ic_done,
    output logic                    oc_done,
    output logic                    tile_done,
    output logic                    conv_done,
    output logic                    busy,
    output logic                    cfg_err
);

    localparam int COL_W = (TILE_COLS > 1) ? $clog2(TILE_COLS) : 1;
    localparam int FL_W  = $clog2(FLUSH_DEPTH);
    localparam logic [FMS_WIDTH-1:0] TC           = FMS_WIDTH'(TILE_COLS);
    localparam logic [FMS_WIDTH-1:0] TR           = FMS_WIDTH'(TILE_ROWS);
    localparam logic [FL_W-1:0]      FLUSH_LAST   = FL_W'(FLUSH_DEPTH - 1);
    localparam logic [COL_W-1:0]     COL_FULL_MAX = COL_W'(TILE_COLS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_CALC} state_t;

    state_t                  state_reg;
    logic [CH_CNT_WIDTH-1:0] chi_reg;
    logic [CH_CNT_WIDTH-1:0] cho_reg;
    logic [CH_CNT_WIDTH-1:0] ic_cnt_reg;
    logic [CH_CNT_WIDTH-1:0] oc_cnt_reg;
    logic [1:0]              stride_reg;
    logic [1:0]              phase_reg;
    logic                    k3_reg;
    logic [FMS_WIDTH-1:0]    ofm_reg;
    logic [FMS_WIDTH-1:0]    tcol_reg;
    logic [FMS_WIDTH-1:0]    trow_reg;
    logic [FL_W-1:0]         flush_cnt_reg;
    logic [COL_W-1:0]        col_reg;
    logic                    cfg_err_reg;

    // Start-time config decode
    logic [FMS_WIDTH-1:0] k_in;
    logic [FMS_WIDTH-1:0] ifm_diff;
    logic [FMS_WIDTH-1:0] ofm_quot;
    logic [FMS_WIDTH-1:0] ofm_next;
    logic                 cfg_bad;

    always_comb begin
        k_in     = cfg_k3 ? FMS_WIDTH'(3) : FMS_WIDTH'(1);
        ifm_diff = ifm_size - k_in;
        case (cfg_stride)
            2'd0:    ofm_quot = ifm_diff;
            2'd1:    ofm_quot = ifm_diff >> 1;
            2'd2:    ofm_quot = ifm_diff / FMS_WIDTH'(3);
            default: ofm_quot = ifm_diff >> 2;
        endcase
        ofm_next = ofm_quot + FMS_WIDTH'(1);
        cfg_bad  = (cfg_chi == '0) || (cfg_cho == '0) || (ifm_size < k_in);
    end

    // Tile geometry; working from ofm-1 keeps every value inside FMS_WIDTH
    logic [FMS_WIDTH-1:0]    ofm_m1;
    logic [FMS_WIDTH-1:0]    last_tcol;
    logic [FMS_WIDTH-1:0]    last_trow;
    logic [FMS_WIDTH-1:0]    col_rem;
    logic [FMS_WIDTH-1:0]    row_rem;
    logic                    is_last_tcol;
    logic                    is_last_trow;
    logic [COL_W-1:0]        col_max;
    logic [TILE_ROWS-1:0]    tile_mask;
    logic [CH_CNT_WIDTH-1:0] chi_m1;
    logic [CH_CNT_WIDTH-1:0] cho_m1;

    assign ofm_m1       = ofm_reg - FMS_WIDTH'(1);
    assign last_tcol    = ofm_m1 / TC;
    assign last_trow    = ofm_m1 / TR;
    assign col_rem      = ofm_m1 % TC;
    assign row_rem      = ofm_m1 % TR;
    assign is_last_tcol = (tcol_reg == last_tcol);
    assign is_last_trow = (trow_reg == last_trow);
    assign col_max      = is_last_tcol ? COL_W'(col_rem) : COL_FULL_MAX;
    assign chi_m1       = chi_reg - CH_CNT_WIDTH'(1);
    assign cho_m1       = cho_reg - CH_CNT_WIDTH'(1);

    genvar gi;
    generate
        for (gi = 0; gi < TILE_ROWS; gi++) begin : g_mask
            assign tile_mask[gi] = !is_last_trow || (FMS_WIDTH'(gi) <= row_rem);
        end
    endgenerate

    logic in_calc;
    logic cnt_valid;
    logic last_col;
    logic ic_done_i;
    logic oc_done_i;
    logic tile_done_i;
    logic conv_done_i;

    assign in_calc     = (state_reg == ST_CALC);
    assign cnt_valid   = in_calc && data_ready && (phase_reg == stride_reg);
    assign last_col    = (col_reg == col_max);
    // An aborting cycle never reports completion
    assign ic_done_i   = cnt_valid && last_col && !abort;
    assign oc_done_i   = ic_done_i && (ic_cnt_reg == chi_m1);
    assign tile_done_i = oc_done_i && (oc_cnt_reg == cho_m1);
    assign conv_done_i = tile_done_i && is_last_tcol && is_last_trow;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= ST_IDLE;
            chi_reg       <= '0;
            cho_reg       <= '0;
            stride_reg    <= '0;
            k3_reg        <= 1'b0;
            ofm_reg       <= '0;
            ic_cnt_reg    <= '0;
            oc_cnt_reg    <= '0;
            tcol_reg      <= '0;
            trow_reg      <= '0;
            phase_reg     <= '0;
            flush_cnt_reg <= '0;
            col_reg       <= '0;
            cfg_err_reg   <= 1'b0;
        end else begin
            cfg_err_reg <= 1'b0;
            if (abort) begin
                state_reg     <= ST_IDLE;
                ic_cnt_reg    <= '0;
                oc_cnt_reg    <= '0;
                tcol_reg      <= '0;
                trow_reg      <= '0;
                phase_reg     <= '0;
                flush_cnt_reg <= '0;
                col_reg       <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        // Counters are already zero here: every loop wraps on conv_done
                        if (start_conv) begin
                            if (cfg_bad) begin
                                cfg_err_reg <= 1'b1;
                            end else begin
                                chi_reg    <= cfg_chi;
                                cho_reg    <= cfg_cho;
                                stride_reg <= cfg_stride;
                                k3_reg     <= cfg_k3;
                                ofm_reg    <= ofm_next;
                                state_reg  <= ST_FLUSH;
                            end
                        end
                    end
                    ST_FLUSH: begin
                        if (data_ready) begin
                            if (flush_cnt_reg == FLUSH_LAST) begin
                                flush_cnt_reg <= '0;
                                state_reg     <= ST_CALC;
                            end else begin
                                flush_cnt_reg <= flush_cnt_reg + FL_W'(1);
                            end
                        end
                    end
                    ST_CALC: begin
                        if (data_ready) begin
                            phase_reg <= (phase_reg == stride_reg) ? 2'd0 : phase_reg + 2'd1;
                            if (cnt_valid) begin
                                col_reg <= last_col ? '0 : col_reg + COL_W'(1);
                            end
                            if (ic_done_i) begin
                                ic_cnt_reg <= oc_done_i ? '0 : ic_cnt_reg + CH_CNT_WIDTH'(1);
                                state_reg  <= conv_done_i ? ST_IDLE : ST_FLUSH;
                            end
                            if (oc_done_i) begin
                                oc_cnt_reg <= tile_done_i ? '0 : oc_cnt_reg + CH_CNT_WIDTH'(1);
                            end
                            if (tile_done_i) begin
                                if (is_last_tcol) begin
                                    tcol_reg <= '0;
                                    trow_reg <= is_last_trow ? '0 : trow_reg + FMS_WIDTH'(1);
                                end else begin
                                    tcol_reg <= tcol_reg + FMS_WIDTH'(1);
                                end
                            end
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    // Free-running pvalid/row_mask delay line, deliberately not stalled
    generate
        for (gi = 0; gi < PVALID_LAT; gi++) begin : g_dly
            logic                 vld_reg;
            logic [TILE_ROWS-1:0] mask_reg;
            logic                 vld_in;
            logic [TILE_ROWS-1:0] mask_in;
            if (gi == 0) begin : g_head
                assign vld_in  = cnt_valid;
                assign mask_in = cnt_valid ? tile_mask : '0;
            end else begin : g_tail
                assign vld_in  = g_dly[gi-1].vld_reg;
                assign mask_in = g_dly[gi-1].mask_reg;
            end
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    vld_reg  <= 1'b0;
                    mask_reg <= '0;
                end else begin
                    vld_reg  <= vld_in;
                    mask_reg <= mask_in;
                end
            end
        end
    endgenerate

    assign pvalid    = g_dly[PVALID_LAT-1].vld_reg;
    assign row_mask  = g_dly[PVALID_LAT-1].mask_reg;
    assign ifm_read  = data_ready && (state_reg != ST_IDLE);
    assign wgt_read  = data_ready && (state_reg == ST_FLUSH) &&
                       (flush_cnt_reg < (k3_reg ? FL_W'(3) : FL_W'(1)));
    assign ic_done   = ic_done_i;
    assign oc_done   = oc_done_i;
    assign tile_done = tile_done_i;
    assign conv_done = conv_done_i;
    assign busy      = (state_reg != ST_IDLE);
    assign cfg_err   = cfg_err_reg;

endmodule

// File: tb/tb_pea_ctrl_gen2.sv
// Directed bench for pea_ctrl_gen2: cycle 0 of each job is the cycle start_conv is high.
module tb_pea_ctrl_gen2;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [9:0] cfg_chi = '0;
    logic [9:0] cfg_cho = '0;
    logic [1:0] cfg_stride = '0;
    logic       cfg_k3 = 1'b0;
    logic [7:0] ifm_size = '0;
    logic       start_conv = 1'b0;
    logic       abort = 1'b0;
    logic       data_ready = 1'b1;
    logic       ifm_read, wgt_read, pvalid;
    logic [7:0] row_mask;
    logic       ic_done, oc_done, tile_done, conv_done, busy, cfg_err;

    always #5 clk = ~clk;

    pea_ctrl_gen2 dut (
        .clk(clk), .rstn(rstn),
        .cfg_chi(cfg_chi), .cfg_cho(cfg_cho), .cfg_stride(cfg_stride), .cfg_k3(cfg_k3),
        .ifm_size(ifm_size), .start_conv(start_conv), .abort(abort), .data_ready(data_ready),
        .ifm_read(ifm_read), .wgt_read(wgt_read), .pvalid(pvalid), .row_mask(row_mask),
        .ic_done(ic_done), .oc_done(oc_done), .tile_done(tile_done), .conv_done(conv_done),
        .busy(busy), .cfg_err(cfg_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Per-job observations
    int   n_ic, n_oc, n_tile, n_conv, n_pv, n_wgt, n_ifm, n_stall_rd;
    int   n_cfg_err, cfg_err_cyc, conv_cyc, first_pv, n_busy;
    int   n_mask_ff, n_mask_01, n_mask_0f, n_mask_other, n_mask_bad;
    int   ic_cyc [8];
    logic busy_hist [256];

    task automatic run_job(input int chi, input int cho, input int stride, input int k3,
                           input int ifm, input int ncyc, input int stall_at, input int stall_len,
                           input int abort_at, input int restart_at);
        n_ic = 0; n_oc = 0; n_tile = 0; n_conv = 0; n_pv = 0; n_wgt = 0; n_ifm = 0;
        n_stall_rd = 0; n_cfg_err = 0; cfg_err_cyc = -1; conv_cyc = -1; first_pv = -1;
        n_busy = 0; n_mask_ff = 0; n_mask_01 = 0; n_mask_0f = 0; n_mask_other = 0;
        n_mask_bad = 0;
        for (int i = 0; i < 8; i++) ic_cyc[i] = -1;
        for (int i = 0; i < 256; i++) busy_hist[i] = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            start_conv = (c == 0) || (c == restart_at);
            cfg_chi    = (c == restart_at) ? 10'd5 : 10'(chi);
            cfg_cho    = 10'(cho);
            cfg_stride = 2'(stride);
            cfg_k3     = (k3 != 0);
            ifm_size   = 8'(ifm);
            abort      = (c == abort_at);
            data_ready = !(c >= stall_at && c < stall_at + stall_len);
            @(negedge clk);
            busy_hist[c] = busy;
            if (busy) n_busy++;
            if (ic_done) begin
                if (n_ic < 8) ic_cyc[n_ic] = c;
                n_ic++;
            end
            if (oc_done) n_oc++;
            if (tile_done) n_tile++;
            if (conv_done) begin n_conv++; conv_cyc = c; end
            if (wgt_read) n_wgt++;
            if (ifm_read) n_ifm++;
            if (!data_ready && ifm_read) n_stall_rd++;
            if (cfg_err) begin n_cfg_err++; cfg_err_cyc = c; end
            if (pvalid) begin
                if (first_pv < 0) first_pv = c;
                n_pv++;
                if (row_mask == 8'hFF) n_mask_ff++;
                else if (row_mask == 8'h01) n_mask_01++;
                else if (row_mask == 8'h0F) n_mask_0f++;
                else n_mask_other++;
            end else if (row_mask != 8'h00) begin
                n_mask_bad++;
            end
        end
        start_conv = 1'b0;
        abort      = 1'b0;
        data_ready = 1'b1;
        $display("job chi=%0d cho=%0d S=%0d k3=%0d ifm=%0d: ic=%0d oc=%0d tile=%0d conv=%0d@%0d pv=%0d wgt=%0d cfg_err=%0d",
                 chi, cho, stride + 1, k3, ifm, n_ic, n_oc, n_tile, n_conv, conv_cyc, n_pv, n_wgt,
                 n_cfg_err);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b want 0", busy); end
        n_cmp++; if (pvalid !== 1'b0) begin n_err++; $display("FAIL rst_pvalid: got %0b want 0", pvalid); end
        n_cmp++; if (row_mask !== 8'h00) begin n_err++; $display("FAIL rst_row_mask: got %h want 00", row_mask); end
        n_cmp++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL rst_cfg_err: got %0b want 0", cfg_err); end
        rstn = 1'b1;
        @(negedge clk);
        n_cmp++; if (ifm_read !== 1'b0) begin n_err++; $display("FAIL rst_ifm_read: got %0b want 0", ifm_read); end
        n_cmp++; if (wgt_read !== 1'b0) begin n_err++; $display("FAIL rst_wgt_read: got %0b want 0", wgt_read); end
        n_cmp++; if (conv_done !== 1'b0) begin n_err++; $display("FAIL rst_conv_done: got %0b want 0", conv_done); end
    endtask

    task automatic test_baseline();
        run_job(2, 1, 0, 1, 18, 95, -1, 0, -1, -1);
        n_cmp++; if (n_ic !== 4) begin n_err++; $display("FAIL base_ic_n: got %0d want 4", n_ic); end
        n_cmp++; if (ic_cyc[0] !== 21) begin n_err++; $display("FAIL base_ic0: got %0d want 21", ic_cyc[0]); end
        n_cmp++; if (ic_cyc[1] !== 42) begin n_err++; $display("FAIL base_ic1: got %0d want 42", ic_cyc[1]); end
        n_cmp++; if (ic_cyc[2] !== 63) begin n_err++; $display("FAIL base_ic2: got %0d want 63", ic_cyc[2]); end
        n_cmp++; if (n_oc !== 2) begin n_err++; $display("FAIL base_oc_n: got %0d want 2", n_oc); end
        n_cmp++; if (n_tile !== 2) begin n_err++; $display("FAIL base_tile_n: got %0d want 2", n_tile); end
        n_cmp++; if (conv_cyc !== 84) begin n_err++; $display("FAIL base_conv_cyc: got %0d want 84", conv_cyc); end
        n_cmp++; if (n_conv !== 1) begin n_err++; $display("FAIL base_conv_n: got %0d want 1", n_conv); end
        n_cmp++; if (n_pv !== 64) begin n_err++; $display("FAIL base_pv_n: got %0d want 64", n_pv); end
        n_cmp++; if (first_pv !== 9) begin n_err++; $display("FAIL base_pv_first: got %0d want 9", first_pv); end
        n_cmp++; if (n_mask_ff !== 64) begin n_err++; $display("FAIL base_mask_ff: got %0d want 64", n_mask_ff); end
        n_cmp++; if (n_mask_bad !== 0) begin n_err++; $display("FAIL base_mask_idle: got %0d want 0", n_mask_bad); end
        n_cmp++; if (n_wgt !== 12) begin n_err++; $display("FAIL base_wgt_n: got %0d want 12", n_wgt); end
        n_cmp++; if (n_ifm !== 84) begin n_err++; $display("FAIL base_ifm_n: got %0d want 84", n_ifm); end
        n_cmp++; if (busy_hist[1] !== 1'b1) begin n_err++; $display("FAIL base_busy_rise: got %0b want 1", busy_hist[1]); end
        n_cmp++; if (busy_hist[85] !== 1'b0) begin n_err++; $display("FAIL base_busy_fall: got %0b want 0", busy_hist[85]); end
    endtask

    task automatic test_stride();
        run_job(1, 1, 1, 1, 19, 55, -1, 0, -1, -1);
        n_cmp++; if (ic_cyc[0] !== 23) begin n_err++; $display("FAIL s2_ic0: got %0d want 23", ic_cyc[0]); end
        n_cmp++; if (conv_cyc !== 46) begin n_err++; $display("FAIL s2_conv_cyc: got %0d want 46", conv_cyc); end
        n_cmp++; if (n_pv !== 18) begin n_err++; $display("FAIL s2_pv_n: got %0d want 18", n_pv); end
        n_cmp++; if (first_pv !== 10) begin n_err++; $display("FAIL s2_pv_first: got %0d want 10", first_pv); end
        n_cmp++; if (n_mask_01 !== 9) begin n_err++; $display("FAIL s2_mask_01: got %0d want 9", n_mask_01); end
        n_cmp++; if (n_mask_ff !== 9) begin n_err++; $display("FAIL s2_mask_ff: got %0d want 9", n_mask_ff); end
        n_cmp++; if (n_wgt !== 6) begin n_err++; $display("FAIL s2_wgt_n: got %0d want 6", n_wgt); end
    endtask

    task automatic test_stall();
        run_job(2, 1, 0, 1, 18, 95, 30, 3, -1, -1);
        n_cmp++; if (ic_cyc[1] !== 45) begin n_err++; $display("FAIL stall_ic1: got %0d want 45", ic_cyc[1]); end
        n_cmp++; if (conv_cyc !== 87) begin n_err++; $display("FAIL stall_conv_cyc: got %0d want 87", conv_cyc); end
        n_cmp++; if (n_pv !== 64) begin n_err++; $display("FAIL stall_pv_n: got %0d want 64", n_pv); end
        n_cmp++; if (n_stall_rd !== 0) begin n_err++; $display("FAIL stall_rd: got %0d want 0", n_stall_rd); end
        n_cmp++; if (n_ifm !== 84) begin n_err++; $display("FAIL stall_ifm_n: got %0d want 84", n_ifm); end
    endtask

    task automatic test_k1();
        run_job(1, 3, 0, 0, 16, 135, -1, 0, -1, -1);
        n_cmp++; if (n_wgt !== 6) begin n_err++; $display("FAIL k1_wgt_n: got %0d want 6", n_wgt); end
        n_cmp++; if (n_oc !== 6) begin n_err++; $display("FAIL k1_oc_n: got %0d want 6", n_oc); end
        n_cmp++; if (n_tile !== 2) begin n_err++; $display("FAIL k1_tile_n: got %0d want 2", n_tile); end
        n_cmp++; if (n_conv !== 1) begin n_err++; $display("FAIL k1_conv_n: got %0d want 1", n_conv); end
        n_cmp++; if (conv_cyc !== 126) begin n_err++; $display("FAIL k1_conv_cyc: got %0d want 126", conv_cyc); end
        n_cmp++; if (n_pv !== 96) begin n_err++; $display("FAIL k1_pv_n: got %0d want 96", n_pv); end
    endtask

    // ofm=20: two tile columns (16 + 4) and three tile rows (8, 8, 4)
    task automatic test_tile_cols();
        run_job(1, 1, 0, 0, 20, 100, -1, 0, -1, -1);
        n_cmp++; if (ic_cyc[1] !== 30) begin n_err++; $display("FAIL tc_ic1: got %0d want 30", ic_cyc[1]); end
        n_cmp++; if (ic_cyc[3] !== 60) begin n_err++; $display("FAIL tc_ic3: got %0d want 60", ic_cyc[3]); end
        n_cmp++; if (conv_cyc !== 90) begin n_err++; $display("FAIL tc_conv_cyc: got %0d want 90", conv_cyc); end
        n_cmp++; if (n_tile !== 6) begin n_err++; $display("FAIL tc_tile_n: got %0d want 6", n_tile); end
        n_cmp++; if (n_pv !== 60) begin n_err++; $display("FAIL tc_pv_n: got %0d want 60", n_pv); end
        n_cmp++; if (n_mask_0f !== 20) begin n_err++; $display("FAIL tc_mask_0f: got %0d want 20", n_mask_0f); end
        n_cmp++; if (n_mask_ff !== 40) begin n_err++; $display("FAIL tc_mask_ff: got %0d want 40", n_mask_ff); end
    endtask

    task automatic test_min_size();
        run_job(1, 1, 0, 1, 3, 15, -1, 0, -1, -1);
        n_cmp++; if (conv_cyc !== 6) begin n_err++; $display("FAIL min_conv_cyc: got %0d want 6", conv_cyc); end
        n_cmp++; if (n_pv !== 1) begin n_err++; $display("FAIL min_pv_n: got %0d want 1", n_pv); end
        n_cmp++; if (n_mask_01 !== 1) begin n_err++; $display("FAIL min_mask_01: got %0d want 1", n_mask_01); end
        n_cmp++; if (n_cfg_err !== 0) begin n_err++; $display("FAIL min_cfg_err: got %0d want 0", n_cfg_err); end
    endtask

    // Abort lands on the cycle pass 3 would complete: no done pulse may escape
    task automatic test_abort();
        run_job(2, 1, 0, 1, 18, 70, -1, 0, 63, -1);
        n_cmp++; if (n_ic !== 2) begin n_err++; $display("FAIL abort_ic_n: got %0d want 2", n_ic); end
        n_cmp++; if (n_conv !== 0) begin n_err++; $display("FAIL abort_conv_n: got %0d want 0", n_conv); end
        n_cmp++; if (busy_hist[63] !== 1'b1) begin n_err++; $display("FAIL abort_busy_at: got %0b want 1", busy_hist[63]); end
        n_cmp++; if (busy_hist[64] !== 1'b0) begin n_err++; $display("FAIL abort_busy_after: got %0b want 0", busy_hist[64]); end
        n_cmp++; if (n_ifm !== 63) begin n_err++; $display("FAIL abort_ifm_n: got %0d want 63", n_ifm); end
    endtask

    // Rerun after abort, with an extra start pulse mid-run that must be ignored
    task automatic test_back_to_back();
        run_job(2, 1, 0, 1, 18, 95, -1, 0, -1, 30);
        n_cmp++; if (ic_cyc[0] !== 21) begin n_err++; $display("FAIL b2b_ic0: got %0d want 21", ic_cyc[0]); end
        n_cmp++; if (ic_cyc[2] !== 63) begin n_err++; $display("FAIL b2b_ic2: got %0d want 63", ic_cyc[2]); end
        n_cmp++; if (conv_cyc !== 84) begin n_err++; $display("FAIL b2b_conv_cyc: got %0d want 84", conv_cyc); end
        n_cmp++; if (n_ic !== 4) begin n_err++; $display("FAIL b2b_ic_n: got %0d want 4", n_ic); end
        n_cmp++; if (n_pv !== 64) begin n_err++; $display("FAIL b2b_pv_n: got %0d want 64", n_pv); end
    endtask

    task automatic test_cfg_err();
        run_job(0, 1, 0, 1, 18, 6, -1, 0, -1, -1);
        n_cmp++; if (n_cfg_err !== 1) begin n_err++; $display("FAIL cerr_chi_n: got %0d want 1", n_cfg_err); end
        n_cmp++; if (cfg_err_cyc !== 1) begin n_err++; $display("FAIL cerr_chi_cyc: got %0d want 1", cfg_err_cyc); end
        n_cmp++; if (n_busy !== 0) begin n_err++; $display("FAIL cerr_chi_busy: got %0d want 0", n_busy); end
        n_cmp++; if (n_ifm !== 0) begin n_err++; $display("FAIL cerr_chi_ifm: got %0d want 0", n_ifm); end
        run_job(1, 1, 0, 1, 2, 6, -1, 0, -1, -1);
        n_cmp++; if (n_cfg_err !== 1) begin n_err++; $display("FAIL cerr_size_n: got %0d want 1", n_cfg_err); end
        n_cmp++; if (cfg_err_cyc !== 1) begin n_err++; $display("FAIL cerr_size_cyc: got %0d want 1", cfg_err_cyc); end
        n_cmp++; if (n_busy !== 0) begin n_err++; $display("FAIL cerr_size_busy: got %0d want 0", n_busy); end
        n_cmp++; if (n_wgt !== 0) begin n_err++; $display("FAIL cerr_size_wgt: got %0d want 0", n_wgt); end
        run_job(1, 0, 0, 0, 18, 6, -1, 0, -1, -1);
        n_cmp++; if (n_cfg_err !== 1) begin n_err++; $display("FAIL cerr_cho_n: got %0d want 1", n_cfg_err); end
        // Abort wins over a valid start in the same cycle
        run_job(1, 1, 0, 1, 18, 6, -1, 0, 0, -1);
        n_cmp++; if (n_busy !== 0) begin n_err++; $display("FAIL abort_start_busy: got %0d want 0", n_busy); end
        n_cmp++; if (n_cfg_err !== 0) begin n_err++; $display("FAIL abort_start_cerr: got %0d want 0", n_cfg_err); end
    endtask

    initial begin
        test_reset();
        test_baseline();
        test_stride();
        test_stall();
        test_k1();
        test_tile_cols();
        test_min_size();
        test_abort();
        test_back_to_back();
        test_cfg_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pea_ctrl_gen2.md
Name: pea_ctrl_gen2

Overview:
Next-generation PE-array controller for the conv engine. It sequences input-channel passes, output-channel passes and output tiles. It drives the IFM/weight read strobes and the per-pixel valid and row mask to the PE array. It extends the previous controller as follows:
- configurable stride (1-4) and kernel size (1x1/3x3)
- arbitrary channel counts
- parametrised tile geometry and flush depth
- a data_ready stall input, abort, and config-error detection

Parameters:
TILE_COLS, 16, output columns per tile (pixel column counter range)
TILE_ROWS, 8, output rows per tile; width of row_mask
CH_CNT_WIDTH, 10, width of channel-count config and counters
FMS_WIDTH, 8, width of ifm_size, ofm size and tile counters
FLUSH_DEPTH, 5, ready-qualified cycles spent in FLUSH per pass (>= 3)
PVALID_LAT, 3, fixed delay from internal count-valid to pvalid/pmask (>= 1)

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
cfg_chi  in  CH_CNT_WIDTH  input channel count (1..2^W-1)
cfg_cho  in  CH_CNT_WIDTH  output channel count
cfg_stride  in  2  stride minus 1 (S = cfg_stride+1)
cfg_k3  in  1  1: 3x3 kernel (K=3), 0: 1x1 (K=1)
ifm_size  in  FMS_WIDTH  input map side length incl. padding
start_conv  in  1  start pulse, sampled only in IDLE
abort  in  1  synchronous abort
data_ready  in  1  buffers can supply data this cycle; 0 stalls all counters
ifm_read  out  1  IFM buffer read strobe
wgt_read  out  1  weight row read strobe
pvalid  out  1  PE output pixel valid
row_mask  out  TILE_ROWS  valid output rows, aligned with pvalid
ic_done  out  1  pulse: one input-channel pass complete
oc_done  out  1  pulse: all input channels of one output channel complete
tile_done  out  1  pulse: all output channels of one tile complete
conv_done  out  1  pulse: whole layer complete
busy  out  1  high from accepted start until conv_done/abort
cfg_err  out  1  one-cycle pulse: start rejected

Behaviour:
- Reset: FSM in IDLE; all counters 0; all outputs 0, including the pvalid/row_mask delay line.
- Start acceptance (start_conv in IDLE):
  - Config is latched at start.
  - Rejected if cfg_chi==0, cfg_cho==0 or ifm_size<K. A rejected start pulses cfg_err next cycle and stays in IDLE.
  - start_conv is ignored when not in IDLE.
- OFM size: ofm = ((ifm_size-K) >> log2 only when S is a power of 2; use integer divide) → ofm = (ifm_size-K)/S + 1, computed in FMS_WIDTH bits at start and registered.
- Tile counts: tiles per axis = ceil(ofm/TILE_COLS) for columns and ceil(ofm/TILE_ROWS) for rows. Last-tile length is ofm mod TILE (use the full TILE if the remainder is 0).
- FSM states: IDLE, FLUSH, CALC.
  - IDLE→FLUSH on an accepted start.
  - FLUSH→CALC after FLUSH_DEPTH data_ready cycles.
  - CALC→FLUSH on ic_done without conv_done.
  - CALC→IDLE on conv_done.
  - Any state→IDLE on abort. Abort has priority over start, same cycle.
- Stall rule: every counter (flush, phase, column, ic, oc, tile) advances only when data_ready=1.
- ifm_read = data_ready & (FLUSH|CALC).
- wgt_read = data_ready during the first K ready cycles of each FLUSH.
- CALC stepping:
  - A phase counter 0..S-1 runs per output column.
  - cnt_valid = CALC & data_ready & phase==S-1.
  - The column counter increments on cnt_valid. Its max is last-tile-col length-1 in the last tile column, else TILE_COLS-1.
- Done pulses (combinational, single cycle):
  - ic_done = cnt_valid & last column.
  - oc_done = ic_done & ic_cnt==chi-1.
  - tile_done = oc_done & oc_cnt==cho-1.
  - conv_done = tile_done & last tile column & last tile row.
  - Each counter wraps to 0 on its own done pulse.
- Loop order, innermost first: ic, oc, tile column, tile row.
- pvalid = cnt_valid delayed exactly PVALID_LAT clocks. The delay line is free-running and not stalled.
- row_mask:
  - Low r bits set in the last tile row when r = ofm mod TILE_ROWS ≠ 0; all ones otherwise.
  - Delayed with pvalid; 0 when pvalid=0.
- busy falls the cycle after conv_done or abort.
- After abort, the next accepted start runs the full layer from zero. No done pulses occur on abort.
- Widths:
  - Channel comparisons use the full CH_CNT_WIDTH with no shifting.
  - Tile counters use FMS_WIDTH and must not overflow for ifm_size up to 2^FMS_WIDTH-1.

Test Plan:
- Baseline: ifm=18, K=3, S=1, chi=2, cho=1, ready=1, start at cycle 0 → ofm=16, 1×2 tiles. ic_done at cycles 21/42/63/84, oc_done at 42/84, conv_done at 84. 64 pvalid pulses, row_mask=8'hFF.
- Stride 2: ifm=19, K=3, S=2, chi=cho=1 → ofm=9. Each pass is 5+18 cycles with pvalid every other cycle, 9 per pass. Second tile row has row_mask=8'h01. conv_done at cycle 46.
- Stall: baseline with data_ready=0 for 3 cycles mid-CALC of pass 2 → conv_done at cycle 87. pvalid count is still 64, and no ifm_read/counter advance while stalled.
- 1x1 kernel: ifm=16, K=1, S=1, chi=1, cho=3 → wgt_read exactly 1 cycle per FLUSH. oc_done ×3, tile_done ×2, conv_done once.
- Abort: assert abort in the CALC of pass 3 → IDLE next cycle, busy=0, no conv_done. Rerun the baseline afterwards → identical timing to the first run.
- Config error: start with chi=0, or with ifm_size=2 and K=3 → cfg_err pulse one cycle later, busy=0, no reads. start_conv asserted while busy → ignored.
